d_ledpwm: RTL and testbench

//  Downstream stage of the LED-bar register: takes its 32-bit pattern (dout_o) and drives the physical LEDs.

---
 rtl/d_ledpwm_pkg.sv | 26 ++
 rtl/d_ledpwm_timebase.sv | 38 +++
 rtl/d_ledpwm.sv | 94 +++++++++
 tb/tb_d_ledpwm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/d_ledpwm_pkg.sv
// Field layout, reset value and the byte-masked write helper for the LED PWM CTRL register.
package d_ledpwm_pkg;

   localparam int DUTY_LSB  = 0;
   localparam int DUTY_W    = 8;
   localparam int PRESC_LSB = 8;
   localparam int PRESC_W   = 8;
   localparam int BHALF_LSB = 16;
   localparam int BHALF_W   = 8;
   localparam int BLINK_BIT = 24;
   localparam int EN_BIT    = 25;
   localparam int PHASE_BIT = 26;

   localparam logic [31:0] CTRL_RST     = 32'h0200_00FF;
   localparam logic [31:0] CTRL_RO_MASK = 32'hFC00_0000;

   // Bytes without their enable keep the current value; read-only bits never store anything.
   function automatic logic [31:0] ctrl_merge(input logic [31:0] cur,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return ((wd & m) | (cur & ~m)) & ~CTRL_RO_MASK;
   endfunction

endpackage

// File: rtl/d_ledpwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter and the period-start pulse.
module d_ledpwm_timebase
   import d_ledpwm_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [PRESC_W-1:0] presc,
   input  logic               en,
   output logic [7:0]         cnt,
   output logic               pstart
);

   logic [PRESC_W-1:0] pcnt;
   logic               restart;
   logic               tick;

   // >= rather than == so that lowering presc below pcnt ticks immediately.
   assign tick   = (pcnt >= presc);
   assign pstart = en & (restart | (tick & (cnt == 8'hFF)));

   always_ff @(posedge clk_i) begin
      if (rst_i || !en) begin
         pcnt    <= '0;
         cnt     <= '0;
         restart <= 1'b1;
      end else if (pstart) begin
         pcnt    <= '0;
         cnt     <= '0;
         restart <= 1'b0;
      end else if (tick) begin
         pcnt    <= '0;
         cnt     <= cnt + 8'd1;
      end else begin
         pcnt    <= pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/d_ledpwm.sv
// LED driver: CTRL register, period-start shadows of pattern/duty, blink phase and the registered LED drive.
module d_ledpwm
   import d_ledpwm_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pattern_i,
   input  logic        we_i,
   input  logic        be0_i,
   input  logic        be1_i,
   input  logic        be2_i,
   input  logic        be3_i,
   input  logic [31:0] din_i,
   output logic [31:0] drd_o,
   output logic [31:0] led_o,
   output logic        pstart_o
);

   logic [31:0]        ctrl;
   logic [3:0]         be;
   logic [DUTY_W-1:0]  duty;
   logic [PRESC_W-1:0] presc;
   logic [BHALF_W-1:0] bhalf;
   logic               blink_en;
   logic               en;

   logic [31:0]        spat;
   logic [DUTY_W-1:0]  sduty;
   logic [BHALF_W-1:0] bcnt;
   logic               phase;
   logic [7:0]         cnt;
   logic               pstart;
   logic               on;

   assign be       = {be3_i, be2_i, be1_i, be0_i};
   assign duty     = ctrl[DUTY_LSB  +: DUTY_W];
   assign presc    = ctrl[PRESC_LSB +: PRESC_W];
   assign bhalf    = ctrl[BHALF_LSB +: BHALF_W];
   assign blink_en = ctrl[BLINK_BIT];
   assign en       = ctrl[EN_BIT];

   // The phase status bit reads 0 while blinking is off, so idle readback equals the stored value.
   assign drd_o = (ctrl & ~CTRL_RO_MASK) | ({31'b0, phase & blink_en} << PHASE_BIT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ctrl <= CTRL_RST;
      end else if (we_i) begin
         ctrl <= ctrl_merge(ctrl, din_i, be);
      end
   end

   d_ledpwm_timebase u_timebase (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .presc  (presc),
      .en     (en),
      .cnt    (cnt),
      .pstart (pstart)
   );

   assign on = (sduty == 8'hFF) | (cnt < sduty);

   // Period-start shadows, blink phase and output stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         spat     <= '0;
         sduty    <= '0;
         bcnt     <= '0;
         phase    <= 1'b1;
         led_o    <= '0;
         pstart_o <= 1'b0;
      end else begin
         pstart_o <= pstart;
         led_o    <= en ? (spat & {32{on & phase}}) : '0;
         if (pstart) begin
            spat  <= pattern_i;
            sduty <= duty;
         end
         if (!en || !blink_en) begin
            phase <= 1'b1;
            bcnt  <= '0;
         end else if (pstart) begin
            if (bcnt == bhalf) begin
               phase <= ~phase;
               bcnt  <= '0;
            end else begin
               bcnt  <= bcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_d_ledpwm.sv
// Randomized scoreboard bench for d_ledpwm against an elapsed-time reference model.
module tb_d_ledpwm;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] pattern_i = '0;
   logic        we_i = 1'b0;
   logic        be0_i = 1'b0, be1_i = 1'b0, be2_i = 1'b0, be3_i = 1'b0;
   logic [31:0] din_i = '0;
   logic [31:0] drd_o, led_o;
   logic        pstart_o;

   d_ledpwm dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .pattern_i (pattern_i),
      .we_i      (we_i),
      .be0_i     (be0_i),
      .be1_i     (be1_i),
      .be2_i     (be2_i),
      .be3_i     (be3_i),
      .din_i     (din_i),
      .drd_o     (drd_o),
      .led_o     (led_o),
      .pstart_o  (pstart_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] led;
      logic        pst;
      logic [31:0] drd;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   logic [31:0] pat;

   // Reference model: time measured as cycles elapsed since the last period start.
   logic [31:0] m_ctrl, m_spat;
   logic [7:0]  m_sduty, m_bcnt;
   logic        m_phase, m_restart;
   int          m_e;

   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h, expected %h at %0t", n, act, exp, $time);
      end
   endfunction

   task automatic model_step(input logic r, input logic w, input logic [3:0] b,
                             input logic [31:0] d, input logic [31:0] p);
      exp_t x;
      logic en, ben, ps, on;
      int   per, cnt;
      if (r) begin
         m_ctrl = 32'h0200_00FF; m_spat = '0; m_sduty = '0; m_bcnt = '0;
         m_phase = 1'b1; m_restart = 1'b1; m_e = 0;
         x.led = '0; x.pst = 1'b0;
      end else begin
         en  = m_ctrl[25];
         ben = m_ctrl[24];
         per = int'(m_ctrl[15:8]) + 1;
         ps  = en && (m_restart || (m_e == 256 * per - 1));
         cnt = m_e / per;
         on  = (m_sduty == 8'hFF) || (cnt < int'(m_sduty));
         x.led = (en && on && m_phase) ? m_spat : 32'h0;
         x.pst = ps;
         if (!en || !ben) begin
            m_phase = 1'b1; m_bcnt = '0;
         end else if (ps) begin
            if (m_bcnt == m_ctrl[23:16]) begin m_phase = ~m_phase; m_bcnt = '0; end
            else m_bcnt = m_bcnt + 8'd1;
         end
         if (!en) begin
            m_e = 0; m_restart = 1'b1;
         end else if (ps) begin
            m_e = 0; m_restart = 1'b0; m_spat = p; m_sduty = m_ctrl[7:0];
         end else begin
            m_e++;
         end
         if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) m_ctrl[8*i +: 8] = d[8*i +: 8];
            m_ctrl[31:26] = '0;
         end
      end
      x.drd = {5'b0, m_phase & m_ctrl[24], m_ctrl[25:0]};
      q.push_back(x);
   endtask

   // Drive one cycle of inputs at the falling edge, record expectations, wait for the next falling edge.
   task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic [31:0] d);
      rst_i = r; we_i = w; {be3_i, be2_i, be1_i, be0_i} = b; din_i = d; pattern_i = pat;
      model_step(r, w, b, d, pat);
      @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 32'h0);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk_i);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("led_o", led_o, x.led);
            chk("pstart_o", {31'b0, pstart_o}, {31'b0, x.pst});
            chk("drd_o", drd_o, x.drd);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [31:0] d;
      logic [3:0]  b;
      int          len;
      @(negedge clk_i);
      // reset and power-on behaviour
      pat = 32'hA5A5_A5A5;
      drive(1'b1, 1'b0, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 4'h0, 32'h0);
      chk("reset_drd", drd_o, 32'h0200_00FF);
      chk("reset_led", led_o, 32'h0);
      idle(2);
      chk("t1_led", led_o, 32'hA5A5_A5A5);
      idle(300);
      // half duty
      pat = 32'h0000_00FF;
      drive(1'b0, 1'b1, 4'hF, 32'h0200_0080);
      idle(800);
      // byte enables
      drive(1'b0, 1'b1, 4'h1, 32'hFFFF_FF10);
      chk("t3_drd", drd_o, 32'h0200_0010);
      // pattern changes mid-period
      for (int i = 0; i < 600; i++) begin
         if (i % 97 == 13) pat = $urandom;
         idle(1);
      end
      // blink
      pat = 32'h1234_5678;
      drive(1'b0, 1'b1, 4'hF, 32'h0301_00FF);
      idle(1500);
      // disable, prescale, re-enable
      drive(1'b0, 1'b1, 4'hF, 32'h0200_00FF);
      idle(300);
      drive(1'b0, 1'b1, 4'hF, 32'h0000_0380);
      idle(1);
      chk("t6_led_off", led_o, 32'h0);
      idle(5);
      drive(1'b0, 1'b1, 4'hF, 32'h0200_0380);
      idle(1);
      chk("t6_pstart", {31'b0, pstart_o}, 32'h1);
      idle(2200);
      // random traffic
      for (int k = 0; k < 25; k++) begin
         len = $urandom_range(50, 700);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 40) == 0) pat = $urandom;
            if ($urandom_range(0, 60) == 0) begin
               d = $urandom;
               b = 4'($urandom_range(0, 15));
               case ($urandom_range(0, 4))
                  0: d[7:0] = 8'h00;
                  1: d[7:0] = 8'hFF;
                  2: d[7:0] = 8'h01;
                  3: d[7:0] = 8'hFE;
                  default: ;
               endcase
               d[15:8]  = 8'($urandom_range(0, 2));
               d[23:16] = 8'($urandom_range(0, 2));
               d[25]    = ($urandom_range(0, 3) != 0);
               // keep the prescaler fixed while running so each period has one length
               if (b[1] && m_ctrl[25] && !(b[3] && !d[25])) b[1] = 1'b0;
               drive(1'b0, 1'b1, b, d);
            end else if ($urandom_range(0, 400) == 0) begin
               drive(1'b1, 1'b1, 4'hF, $urandom);
            end else begin
               idle(1);
            end
         end
      end
      idle(2);
      chk("queue_drained", q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
